mac_stream_feeder: RTL and testbench
====================================

Name: mac_stream_feeder

Overview:
- Source end of the MAC operand interface: stores a J-entry operand vector v and a J-beat matrix stream (one A-lane column per beat) in local RAM.
- On start, streams len beats onto the vinput/M_row AXI-Stream-style buses with tlast on the final beat.
- Waits for the MAC's beta_tvalid, captures beta into a result register and reports done.
- The MAC interface has no tready, so the feeder emits one beat per cycle with no gaps.

Parameters:
- J, 14, maximum beats per run (vector length, RAM depth)
- A, 2, number of 64-bit lanes per M_row beat (number of MAC outputs)
- J_WIDTH, $clog2(J)+1, local: width of addresses and len

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- v_wr_en  in  1  write strobe, vector RAM
- v_wr_addr  in  J_WIDTH  vector RAM address
- v_wr_data  in  64  vector element (IEEE double bits, opaque here)
- m_wr_en  in  1  write strobe, matrix RAM
- m_wr_addr  in  J_WIDTH  matrix RAM address (beat index)
- m_wr_data  in  A*64  one beat; lane i at [i*64 +: 64]
- start  in  1  single-cycle run request
- len  in  J_WIDTH  beats for this run, sampled with start
- busy  out  1  high from accepted start until done pulse
- cfg_err  out  1  one-cycle pulse: start rejected (bad len)
- vinput  out  64  vector beat
- vinput_tvalid  out  1  beat valid
- vinput_tlast  out  1  last beat of run
- M_row  out  A*64  matrix beat
- M_row_tvalid  out  1  equals vinput_tvalid
- M_row_tlast  out  1  equals vinput_tlast
- beta_tvalid  in  1  MAC result strobe (final accumulation)
- beta  in  A*64  MAC result
- result  out  A*64  captured beta, held until next capture
- done  out  1  one-cycle pulse on capture

Behaviour:
- Reset values: busy=0, cfg_err=0, done=0, all tvalid/tlast=0, vinput=0, M_row=0, result=0, FSM=IDLE. RAM contents are not reset.
- Reset asserted mid-run: immediately drops tvalid/tlast/busy. A beta arriving later is ignored because the FSM is in IDLE.
- Writes:
  - Accepted only in IDLE with addr < J.
  - Writes with addr >= J, or while busy, are dropped silently.
  - v and m writes are independent and may occur in the same cycle.
- RAM read is registered (1 cycle).
- FSM states: IDLE, STREAM, WAIT, DONE.
- IDLE:
  - start with 1 <= len <= J: latch len, reset beat counter k=0, busy=1 next cycle, go STREAM.
  - start with len=0 or len>J: cfg_err=1 for one cycle, stay IDLE.
  - A write and start in the same cycle: the write is committed before the first read, so the streamed value is the new one.
- STREAM:
  - Issue read address k each cycle, k = 0..len-1.
  - Beat k appears on the outputs 1 cycle after its read, so start at cycle t gives the first valid beat at t+2.
  - Exactly len consecutive valid beats, no bubbles.
  - tlast=1 only on beat len-1; len=1 gives a single beat with tlast=1.
  - After the read for len-1 is issued, go WAIT; the final beat is driven in the first WAIT cycle.
  - vinput/M_row hold the last value when tvalid=0 (only tvalid is meaningful).
- WAIT:
  - tvalid=0 after the final beat.
  - On beta_tvalid=1: result<=beta, done=1 next cycle, go DONE.
  - No timeout; a stuck MAC keeps busy=1 until reset.
- DONE: one cycle; done=1, busy=0 at the same edge, return to IDLE. start is accepted again in the following cycle.
- beta_tvalid in IDLE/STREAM/DONE: ignored, result unchanged.
- start while busy: ignored, no cfg_err.
- Counter k is J_WIDTH wide, so the k=J-1 terminal condition cannot wrap.
- Per-lane MAC latencies are not observed. Only beta_tvalid, which the MAC asserts on its last lane's tlast, gates capture.

Test Plan:
- Reset then idle: hold rst 3 cycles, release, no stimulus -> all outputs 0, busy=0 for 20 cycles.
- Full run, J=14, A=2: write v[k]=k, M[k]={lane1=k+100, lane0=k+200}, start with len=14 at cycle t.
  - Beats t+2..t+15 carry vinput=0..13 and M_row lanes as written.
  - tlast only at t+15; busy=1 from t+1.
  - Drive beta={A,B} 5 cycles later -> result={A,B}, done pulse, busy=0 on the same edge.
- Boundary len: len=1 -> single beat v[0] with tlast=1. len=0 and len=15 -> cfg_err pulse, busy stays 0, no tvalid.
- Illegal writes:
  - Write m_wr_addr=14 -> RAM unchanged (read back via a len=14 run).
  - Writes during STREAM are dropped and the streamed data is unchanged.
  - Write v[0]=0xAA in the same cycle as start -> first beat vinput=0xAA.
- Stray/late events:
  - beta_tvalid during STREAM -> result unchanged, no done.
  - start during WAIT -> ignored.
  - rst asserted at the 5th beat -> tvalid drops immediately; a subsequent beta_tvalid does not set done.
- Back-to-back: start again in the cycle after done -> second run's first beat at +2 cycles, identical timing to the first run.

Source files
------------

// File: rtl/mac_stream_feeder_if.sv
// mac_stream_feeder_if: operand/result bus between the stream feeder and the MAC.
//   vinput / vinput_tvalid / vinput_tlast : vector beat stream (feeder -> MAC)
//   M_row / M_row_tvalid / M_row_tlast    : matrix beat stream, A 64-bit lanes (feeder -> MAC)
//   beta_tvalid / beta                    : final accumulation result (MAC -> feeder)
// There is no tready: the MAC must accept one beat per cycle.
interface mac_stream_feeder_if #(
  parameter int unsigned A = 2
);
  logic [63:0]     vinput;
  logic            vinput_tvalid;
  logic            vinput_tlast;
  logic [A*64-1:0] M_row;
  logic            M_row_tvalid;
  logic            M_row_tlast;
  logic            beta_tvalid;
  logic [A*64-1:0] beta;

  modport master (
    output vinput, vinput_tvalid, vinput_tlast,
    output M_row, M_row_tvalid, M_row_tlast,
    input  beta_tvalid, beta
  );

  modport slave (
    input  vinput, vinput_tvalid, vinput_tlast,
    input  M_row, M_row_tvalid, M_row_tlast,
    output beta_tvalid, beta
  );
endinterface

// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder: source end of the MAC operand interface.
// Holds a J-entry operand vector and a J-beat matrix (A lanes per beat) in local RAM. On start
// it streams len gap-free beats onto the MAC bus (tlast on the final beat), then waits for the
// MAC's beta_tvalid, captures beta into result and pulses done.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   v_wr_en/v_wr_addr/v_wr_data    vector RAM write (IDLE only, addr < J)
//   m_wr_en/m_wr_addr/m_wr_data    matrix RAM write (IDLE only, addr < J)
//   start, len                     run request; len sampled with start, legal 1..J
//   busy                           high from accepted start until done
//   cfg_err                        one-cycle pulse when start is rejected for a bad len
//   mac                            MAC bus (master side)
//   result, done                   captured beta, one-cycle capture pulse
module mac_stream_feeder #(
  parameter int unsigned J = 14,
  parameter int unsigned A = 2,
  localparam int unsigned J_WIDTH = $clog2(J) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   v_wr_en,
  input  logic [J_WIDTH-1:0]     v_wr_addr,
  input  logic [63:0]            v_wr_data,
  input  logic                   m_wr_en,
  input  logic [J_WIDTH-1:0]     m_wr_addr,
  input  logic [A*64-1:0]        m_wr_data,
  input  logic                   start,
  input  logic [J_WIDTH-1:0]     len,
  output logic                   busy,
  output logic                   cfg_err,
  mac_stream_feeder_if.master    mac,
  output logic [A*64-1:0]        result,
  output logic                   done
);

  // RAM index width; the J_WIDTH-wide addresses are range-checked before slicing.
  localparam int unsigned AW = (J > 1) ? $clog2(J) : 1;
  localparam logic [J_WIDTH-1:0] JMax = J_WIDTH'(J);

  typedef enum logic [1:0] {StIdle, StStream, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic [J_WIDTH-1:0] k_q, k_d;
  logic [J_WIDTH-1:0] len_q, len_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               cfg_err_q, cfg_err_d;
  logic               rd_en;
  logic               capture;
  logic               last_beat;
  logic               v_we, m_we;

  logic [63:0]     v_mem [J];
  logic [A*64-1:0] m_mem [J];

  logic [63:0]     vinput_q;
  logic [A*64-1:0] m_row_q;
  logic [A*64-1:0] result_q;

  // Writes only while idle, so a run always streams a stable snapshot of the RAM.
  assign v_we = v_wr_en && (state_q == StIdle) && (v_wr_addr < JMax);
  assign m_we = m_wr_en && (state_q == StIdle) && (m_wr_addr < JMax);

  always_ff @(posedge clk) begin
    if (v_we) v_mem[v_wr_addr[AW-1:0]] <= v_wr_data;
    if (m_we) m_mem[m_wr_addr[AW-1:0]] <= m_wr_data;
  end

  assign last_beat = (k_q == len_q - J_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    cfg_err_d = 1'b0;
    rd_en     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((len != '0) && (len <= JMax)) begin
            len_d   = len;
            k_d     = '0;
            state_d = StStream;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StStream: begin
        // Read issued now; the beat and its flags appear on the bus next cycle.
        rd_en    = 1'b1;
        tvalid_d = 1'b1;
        tlast_d  = last_beat;
        if (last_beat) begin
          state_d = StWait;
        end else begin
          k_d = k_q + J_WIDTH'(1);
        end
      end
      StWait: begin
        if (mac.beta_tvalid) begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      len_q     <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      vinput_q  <= '0;
      m_row_q   <= '0;
      result_q  <= '0;
    end else begin
      k_q       <= k_d;
      len_q     <= len_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      cfg_err_q <= cfg_err_d;
      // Data holds its last value between runs; only tvalid qualifies it.
      if (rd_en) begin
        vinput_q <= v_mem[k_q[AW-1:0]];
        m_row_q  <= m_mem[k_q[AW-1:0]];
      end
      if (capture) result_q <= mac.beta;
    end
  end

  assign busy    = (state_q == StStream) || (state_q == StWait);
  assign done    = (state_q == StDone);
  assign cfg_err = cfg_err_q;
  assign result  = result_q;

  assign mac.vinput        = vinput_q;
  assign mac.vinput_tvalid = tvalid_q;
  assign mac.vinput_tlast  = tlast_q;
  assign mac.M_row         = m_row_q;
  assign mac.M_row_tvalid  = tvalid_q;
  assign mac.M_row_tlast   = tlast_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Directed bench for mac_stream_feeder: a RAM model feeds a beat scoreboard at each start,
// beats are popped and compared at the cycles they must appear.
module tb_mac_stream_feeder;
  localparam int unsigned J  = 14;
  localparam int unsigned A  = 2;
  localparam int unsigned JW = $clog2(J) + 1;
  localparam int unsigned MW = A * 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v_wr_en = 1'b0;
  logic [JW-1:0] v_wr_addr = '0;
  logic [63:0]   v_wr_data = '0;
  logic          m_wr_en = 1'b0;
  logic [JW-1:0] m_wr_addr = '0;
  logic [MW-1:0] m_wr_data = '0;
  logic          start = 1'b0;
  logic [JW-1:0] len = '0;
  logic          busy;
  logic          cfg_err;
  logic [MW-1:0] result;
  logic          done;

  mac_stream_feeder_if #(.A(A)) mac_if ();

  mac_stream_feeder #(.J(J), .A(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .v_wr_en   (v_wr_en),
    .v_wr_addr (v_wr_addr),
    .v_wr_data (v_wr_data),
    .m_wr_en   (m_wr_en),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .mac       (mac_if),
    .result    (result),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0]   v_model [J];
  logic [MW-1:0] m_model [J];
  logic [63:0]   q_v [$];
  logic [MW-1:0] q_m [$];
  bit            q_last [$];
  logic [MW-1:0] exp_result = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int k, input logic [63:0] vd, input logic [MW-1:0] md);
    v_wr_en = 1'b1; v_wr_addr = JW'(k); v_wr_data = vd;
    m_wr_en = 1'b1; m_wr_addr = JW'(k); m_wr_data = md;
    tick();
    v_wr_en = 1'b0; m_wr_en = 1'b0;
    if (k < J) begin
      v_model[k] = vd;
      m_model[k] = md;
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tvalid"}, mac_if.vinput_tvalid, 0);
    chk({tag, "_tlast"}, mac_if.vinput_tlast, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Start a run of n beats; abort_beat >= 0 asserts rst while that beat is on the bus.
  task automatic run_stream(input int n, input int abort_beat, input bit stray,
                            input bit start_in_wait);
    logic [63:0]   ev;
    logic [MW-1:0] em;
    bit            el;
    for (int k = 0; k < n; k++) begin
      q_v.push_back(v_model[k]);
      q_m.push_back(m_model[k]);
      q_last.push_back(k == n - 1);
    end
    start = 1'b1; len = JW'(n);
    tick();
    start = 1'b0; v_wr_en = 1'b0; m_wr_en = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("tvalid_before_first_beat", mac_if.vinput_tvalid, 0);
    for (int b = 0; b < n; b++) begin
      if (stray) begin
        mac_if.beta_tvalid = 1'b1; mac_if.beta = {2{64'hBAD0_BAD0_BAD0_BAD0}};
        v_wr_en = 1'b1; v_wr_addr = JW'(n - 1); v_wr_data = 64'hDEAD;
        m_wr_en = 1'b1; m_wr_addr = JW'(n - 1); m_wr_data = {2{64'hDEAD}};
      end
      tick();
      mac_if.beta_tvalid = 1'b0; v_wr_en = 1'b0; m_wr_en = 1'b0;
      ev = q_v.pop_front(); em = q_m.pop_front(); el = q_last.pop_front();
      chk("vinput_tvalid", mac_if.vinput_tvalid, 1);
      chk("M_row_tvalid", mac_if.M_row_tvalid, 1);
      chk("vinput", mac_if.vinput, ev);
      chk("M_row", mac_if.M_row, em);
      chk("vinput_tlast", mac_if.vinput_tlast, el);
      chk("M_row_tlast", mac_if.M_row_tlast, el);
      chk("busy_streaming", busy, 1);
      if (stray) begin
        chk("stray_beta_done", done, 0);
        chk("stray_beta_result", result, exp_result);
      end
      if (b == abort_beat) begin
        rst = 1'b1;
        #1;
        chk("abort_tvalid", mac_if.vinput_tvalid, 0);
        chk("abort_M_row_tvalid", mac_if.M_row_tvalid, 0);
        chk("abort_tlast", mac_if.vinput_tlast, 0);
        chk("abort_busy", busy, 0);
        tick();
        rst = 1'b0;
        q_v.delete(); q_m.delete(); q_last.delete();
        exp_result = '0;
        return;
      end
    end
    // WAIT: five quiet cycles after the final beat, optionally with a stray start.
    for (int i = 0; i < 5; i++) begin
      if (start_in_wait && i == 2) begin
        start = 1'b1; len = JW'(3);
      end
      tick();
      start = 1'b0;
      chk("wait_tvalid", mac_if.vinput_tvalid, 0);
      chk("wait_tlast", mac_if.vinput_tlast, 0);
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
      chk("wait_cfg_err", cfg_err, 0);
    end
  endtask

  task automatic finish_run(input logic [MW-1:0] bval);
    mac_if.beta_tvalid = 1'b1; mac_if.beta = bval;
    tick();
    mac_if.beta_tvalid = 1'b0; mac_if.beta = '0;
    exp_result = bval;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("result_capture", result, exp_result);
    tick();
    chk("done_cleared", done, 0);
    chk("busy_after_done", busy, 0);
    chk("result_held", result, exp_result);
  endtask

  task automatic bad_start(input int n);
    start = 1'b1; len = JW'(n);
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_tvalid", mac_if.vinput_tvalid, 0);
    tick();
    chk("cfg_err_cleared", cfg_err, 0);
    chk("cfg_err_busy_after", busy, 0);
    chk("cfg_err_tvalid_after", mac_if.vinput_tvalid, 0);
  endtask

  initial begin
    mac_if.beta_tvalid = 1'b0;
    mac_if.beta = '0;

    // Reset then idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_checks("in_reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      idle_checks("idle");
    end
    chk("reset_vinput", mac_if.vinput, '0);
    chk("reset_M_row", mac_if.M_row, '0);
    chk("reset_result", result, '0);

    // Load RAMs, then out-of-range writes that must be dropped.
    for (int k = 0; k < J; k++) begin
      wr(k, 64'(k), {64'(k + 100), 64'(k + 200)});
    end
    wr(14, 64'hEEEE, {2{64'hEEEE}});
    wr(15, 64'hFFFF, {2{64'hFFFF}});

    // Full run with a start during WAIT that must be ignored.
    run_stream(14, -1, 1'b0, 1'b1);
    finish_run({64'h0000_0000_0000_00AA, 64'h0000_0000_0000_00BB});

    // Boundary lengths.
    run_stream(1, -1, 1'b0, 1'b0);
    finish_run({64'h1111, 64'h2222});
    bad_start(0);
    bad_start(15);

    // Stray beta and writes during STREAM.
    run_stream(14, -1, 1'b1, 1'b0);
    finish_run({64'h3333, 64'h4444});

    // Write in the same cycle as start: the new value is streamed.
    v_wr_en = 1'b1; v_wr_addr = '0; v_wr_data = 64'hAA;
    v_model[0] = 64'hAA;
    run_stream(2, -1, 1'b0, 1'b0);
    finish_run({64'h5555, 64'h6666});

    // Back-to-back: start in the cycle right after the done pulse.
    run_stream(3, -1, 1'b0, 1'b0);
    finish_run({64'h7777, 64'h8888});

    // Reset during the fifth beat; a later beta is ignored.
    run_stream(14, 4, 1'b0, 1'b0);
    tick();
    mac_if.beta_tvalid = 1'b1; mac_if.beta = {2{64'h9999}};
    tick();
    mac_if.beta_tvalid = 1'b0;
    chk("post_abort_done", done, 0);
    chk("post_abort_result", result, exp_result);
    chk("post_abort_busy", busy, 0);
    tick();
    chk("post_abort_done_later", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
